// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU datapath types: machine word, ALU opcodes and the
//                ALU scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int SCHED_NREQ = 2;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin grant selection. A lone
//                requester always wins; on contention the prio input decides.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       prio,
    output logic       grant,
    output logic       grant_valid
);

    // Pick the winner: single requester wins outright, a tie goes to prio
    always_comb begin
        grant_valid = |req_valid;
        grant       = (req_valid == 2'b11) ? prio : req_valid[1];
    end

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sched
//  Description : Shares one external ALU between two requesters. Round-robin
//                arbitration, registered operands, one EXEC cycle, then the
//                captured result/flags are returned on a valid/ready response
//                to the granted requester.
//                Optional grant counters enabled by `define ALU_SCHED_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sched
    import cpu_types_pkg::*;
#(
    parameter int NREQ  = SCHED_NREQ,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef ALU_SCHED_STATS_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
`endif
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [7:0]       req_opcode,
    input  logic [63:0]      req_port_a,
    input  logic [63:0]      req_port_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_port_o,
    output logic             rsp_negative,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic [3:0]       alu_opcode,
    output logic [31:0]      alu_port_a,
    output logic [31:0]      alu_port_b,
    input  logic [31:0]      alu_port_o,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             busy
);

    // The datapath is hard-wired for exactly two requesters
    if (NREQ != 2 || CNT_W < 1) begin : g_bad_param
        $error("alu_sched supports only NREQ == 2 and CNT_W >= 1");
    end

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic         r_prio;
    logic         r_owner;
    logic [3:0]   r_opcode;
    word_t        r_port_a;
    word_t        r_port_b;
    word_t        r_result;
    logic         r_negative;
    logic         r_overflow;
    logic         r_zero;
    logic         w_grant;
    logic         w_grant_valid;
    logic         w_accept;
    logic [3:0]   w_sel_opcode;
    word_t        w_sel_port_a;
    word_t        w_sel_port_b;

    rr_arb2 u_arb (
        .req_valid   (req_valid),
        .prio        (r_prio),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // Operand fields of whichever requester currently holds the grant
    always_comb begin
        w_sel_opcode = w_grant ? req_opcode[7:4]  : req_opcode[3:0];
        w_sel_port_a = w_grant ? req_port_a[63:32] : req_port_a[31:0];
        w_sel_port_b = w_grant ? req_port_b[63:32] : req_port_b[31:0];
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and request/response handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    req_ready[w_grant] = 1'b1;
                    w_accept           = 1'b1;
                    w_state_nxt        = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, result capture at the end of EXEC
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prio     <= 1'b0;
            r_owner    <= 1'b0;
            r_opcode   <= 4'h0;
            r_port_a   <= '0;
            r_port_b   <= '0;
            r_result   <= '0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opcode <= w_sel_opcode;
                r_port_a <= w_sel_port_a;
                r_port_b <= w_sel_port_b;
                r_owner  <= w_grant;
                r_prio   <= ~w_grant;
            end
            if (r_state == EXEC) begin
                r_result   <= alu_port_o;
                r_negative <= alu_negative;
                r_overflow <= alu_overflow;
                r_zero     <= alu_zero;
            end
        end
    end

    assign alu_opcode   = r_opcode;
    assign alu_port_a   = r_port_a;
    assign alu_port_b   = r_port_b;
    assign rsp_port_o   = r_result;
    assign rsp_negative = r_negative;
    assign rsp_overflow = r_overflow;
    assign rsp_zero     = r_zero;
    assign busy         = (r_state != IDLE);

`ifdef ALU_SCHED_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Saturating per-requester grant counters; clear beats a same-cycle grant
    always_ff @(posedge CLK) begin
        if (RST || cnt_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_grant && (r_cnt0 != {CNT_W{1'b1}})) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_grant && (r_cnt1 != {CNT_W{1'b1}})) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sched
//  Description : Self-checking bench for alu_sched with a behavioural ALU and
//                a transaction-level reference model.
//                Exercises grant counters when ALU_SCHED_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sched;
    import cpu_types_pkg::*;

`ifdef ALU_SCHED_STATS_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  rsp_ready = 2'b00;
    logic [7:0]  req_opcode = '0;
    logic [63:0] req_port_a = '0;
    logic [63:0] req_port_b = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_port_o;
    logic        rsp_negative, rsp_overflow, rsp_zero;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_port_a, alu_port_b, alu_port_o;
    logic        alu_negative, alu_overflow, alu_zero;
    logic        busy;
`ifdef ALU_SCHED_STATS_EN
    logic                cnt_clr = 1'b0;
    logic [TB_CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    int n_vec = 0;
    int n_err = 0;

    alu_sched #(.NREQ(2), .CNT_W(TB_CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
`ifdef ALU_SCHED_STATS_EN
        .cnt_clr      (cnt_clr),
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
`endif
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_port_a   (req_port_a),
        .req_port_b   (req_port_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_port_o   (rsp_port_o),
        .rsp_negative (rsp_negative),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .alu_opcode   (alu_opcode),
        .alu_port_a   (alu_port_a),
        .alu_port_b   (alu_port_b),
        .alu_port_o   (alu_port_o),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    // Reference ALU: returns {negative, overflow, zero, result}
    function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            4'h0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'h1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            default: r = 32'h0;
        endcase
        return {r[31], v, (r == 32'h0), r};
    endfunction

    always_comb {alu_negative, alu_overflow, alu_zero, alu_port_o} = ref_alu(alu_opcode, alu_port_a, alu_port_b);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_age: -1 no operation in flight, 0 operation accepted (ALU working),
    // 1 response outstanding.
    int          m_age = -1;
    logic        m_prio = 1'b0;
    logic        m_owner = 1'b0;
    logic [34:0] m_res = '0;
    logic [3:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0;
    int          m_cnt0 = 0, m_cnt1 = 0;
    logic        m_g;
    int          m_max;

    always @(posedge CLK) begin
        m_max = (1 << TB_CNT_W) - 1;
        if (RST) begin
            m_age = -1; m_prio = 1'b0; m_owner = 1'b0; m_res = '0;
            m_op = '0; m_a = '0; m_b = '0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            if (m_age < 0) begin
                if (req_valid != 2'b00) begin
                    m_g     = (req_valid == 2'b11) ? m_prio : (req_valid == 2'b10);
                    m_owner = m_g;
                    m_prio  = !m_g;
                    m_op    = m_g ? req_opcode[7:4]   : req_opcode[3:0];
                    m_a     = m_g ? req_port_a[63:32] : req_port_a[31:0];
                    m_b     = m_g ? req_port_b[63:32] : req_port_b[31:0];
                    m_res   = ref_alu(m_op, m_a, m_b);
                    m_age   = 0;
                    if (!m_g && m_cnt0 < m_max) m_cnt0++;
                    if (m_g && m_cnt1 < m_max) m_cnt1++;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (rsp_ready[m_owner]) begin
                m_age = -1;
            end
`ifdef ALU_SCHED_STATS_EN
            if (cnt_clr) begin m_cnt0 = 0; m_cnt1 = 0; end
`endif
        end
    end

    // Compare process: every negedge, all outputs versus the model
    logic [1:0] e_rr, e_rv;
    logic       e_g;
    always @(negedge CLK) begin
        e_rr = 2'b00;
        e_rv = 2'b00;
        if (m_age < 0 && req_valid != 2'b00) begin
            e_g = (req_valid == 2'b11) ? m_prio : (req_valid == 2'b10);
            e_rr[e_g] = 1'b1;
        end
        if (m_age == 1) e_rv[m_owner] = 1'b1;
        check("m_req_ready", 64'(req_ready), 64'(e_rr));
        check("m_rsp_valid", 64'(rsp_valid), 64'(e_rv));
        check("m_busy", 64'(busy), 64'(m_age >= 0));
        check("m_alu_operands", {20'h0, alu_opcode, alu_port_a, alu_port_b}, {20'h0, m_op, m_a, m_b});
        if (m_age != 0)
            check("m_rsp_data", 64'({rsp_negative, rsp_overflow, rsp_zero, rsp_port_o}), 64'(m_res));
`ifdef ALU_SCHED_STATS_EN
        check("m_cnt", {32'(grant_cnt0), 32'(grant_cnt1)}, {32'(m_cnt0), 32'(m_cnt1)});
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_opcode[i*4 +: 4]  = op;
        req_port_a[i*32 +: 32] = a;
        req_port_b[i*32 +: 32] = b;
        req_valid[i]           = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        int n;
        n = 0;
        #1;
        while (!req_ready[i] && n < 30) begin
            tick();
            #1;
            n++;
        end
        if (!req_ready[i]) check("accept_timeout", 64'd0, 64'd1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        #1;
        while (busy && n < 30) begin
            tick();
            #1;
            n++;
        end
        if (busy) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        rsp_ready = 2'b11;
        set_req(i, op, a, b);
        wait_accept(i);
        wait_idle();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed tests ----------------
    initial begin
        int grants[$];
        int n;

        // Reset state
        do_reset();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_alu", {alu_opcode, alu_port_a, alu_port_b}, 68'd0);
        check("rst_rsp_data", 64'({rsp_negative, rsp_overflow, rsp_zero, rsp_port_o}), 64'd0);

        // ADD 5 + 3 from requester 0
        rsp_ready = 2'b01;
        set_req(0, ALU_ADD, 32'h5, 32'h3);
        #1;
        check("add_req_ready", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        check("add_rsp_valid", 64'(rsp_valid), 64'b01);
        check("add_port_o", 64'(rsp_port_o), 64'h8);
        check("add_zero", 64'(rsp_zero), 64'd0);
        tick();
        wait_idle();

        // Contention from reset: grants alternate starting with 0
        do_reset();
        rsp_ready = 2'b11;
        set_req(0, ALU_ADD, 32'h10, 32'h1);
        set_req(1, ALU_XOR, 32'hF0F0, 32'h0FF0);
        n = 0;
        while (grants.size() < 4 && n < 60) begin
            #1;
            if (req_ready != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
            if (grants.size() == 4) begin
                tick();
                req_valid = 2'b00;
            end else begin
                tick();
            end
            n++;
        end
        check("rr_count", 64'(grants.size()), 64'd4);
        if (grants.size() == 4) begin
            check("rr_grant0", 64'(grants[0]), 64'd0);
            check("rr_grant1", 64'(grants[1]), 64'd1);
            check("rr_grant2", 64'(grants[2]), 64'd0);
            check("rr_grant3", 64'(grants[3]), 64'd1);
        end
        wait_idle();

        // SUB overflow from requester 1 with a stalled response
        rsp_ready = 2'b00;
        set_req(1, ALU_SUB, 32'h8000_0000, 32'h1);
        wait_accept(1);
        set_req(0, ALU_ADD, 32'h1, 32'h2);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_rsp_valid", 64'(rsp_valid), 64'b10);
            check("stall_port_o", 64'(rsp_port_o), 64'h7FFF_FFFF);
            check("stall_overflow", 64'(rsp_overflow), 64'd1);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 2'b10;
        tick();
        #1;
        check("pending_req0_ready", 64'(req_ready), 64'b01);
        rsp_ready = 2'b11;
        wait_accept(0);
        wait_idle();

        // Zero flag; non-owner rsp_ready is ignored
        rsp_ready = 2'b10;
        set_req(0, ALU_SUB, 32'h1234_5678, 32'h1234_5678);
        wait_accept(0);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("own_rsp_valid", 64'(rsp_valid), 64'b01);
            check("own_zero", 64'(rsp_zero), 64'd1);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        #1;
        check("own_done_busy", 64'(busy), 64'd0);

        // Reset during EXEC drops the operation and restores prio 0
        rsp_ready = 2'b11;
        set_req(0, ALU_ADD, 32'h7, 32'h7);
        wait_accept(0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check("drop_busy", 64'(busy), 64'd0);
        check("drop_rsp_valid", 64'(rsp_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            check("drop_no_rsp", 64'(rsp_valid), 64'd0);
        end
        req_valid = 2'b11;
        #1;
        check("drop_prio0", 64'(req_ready), 64'b01);
        req_valid = 2'b00;
        tick();

`ifdef ALU_SCHED_STATS_EN
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        run_op(0, ALU_ADD, 32'h1, 32'h1);
        run_op(1, ALU_ADD, 32'h2, 32'h2);
        run_op(0, ALU_AND, 32'h3, 32'h1);
        run_op(1, ALU_OR, 32'h4, 32'h1);
        run_op(0, ALU_XOR, 32'h5, 32'h1);
        #1;
        check("stat_cnt0", 64'(grant_cnt0), 64'd3);
        check("stat_cnt1", 64'(grant_cnt1), 64'd2);
        rsp_ready = 2'b11;
        set_req(0, ALU_ADD, 32'h9, 32'h9);
        #1;
        check("clr_accept_ready", 64'(req_ready), 64'b01);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        req_valid = 2'b00;
        #1;
        check("clr_cnt0", 64'(grant_cnt0), 64'd0);
        check("clr_cnt1", 64'(grant_cnt1), 64'd0);
        wait_idle();
        for (int k = 0; k < 5; k++) run_op(0, ALU_ADD, 32'(k), 32'h1);
        #1;
        check("sat_cnt0", 64'(grant_cnt0), 64'd3);
        check("sat_cnt1", 64'(grant_cnt1), 64'd0);
`else
        run_op(1, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        run_op(0, ALU_OR, 32'h0, 32'h0);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
